// File: rtl/hamming_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming_decoder : two-stage Hamming(12,8) SEC decoder with error counters
// Revision 1.0
// ---------------------------------------------------------------------------
module hamming_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic             in_valid,
   input  logic [11:0]      hc_in,
   input  logic             cnt_clr,
   output logic             out_valid,
   output logic [7:0]       data_out,
   output logic             err_corr,
   output logic             err_uncorr,
   output logic [3:0]       syndrome_out,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [3:0] calc_syn(input logic [11:0] c);
      calc_syn[0] = c[0] ^ c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
      calc_syn[1] = c[1] ^ c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
      calc_syn[2] = c[3] ^ c[4] ^ c[5] ^ c[6] ^ c[11];
      calc_syn[3] = c[7] ^ c[8] ^ c[9] ^ c[10] ^ c[11];
   endfunction

   function automatic logic [7:0] extract(input logic [11:0] c);
      extract = {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
   endfunction

   logic        s1_valid;
   logic [11:0] s1_code;
   logic [3:0]  s1_syn;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_code  <= in_valid ? hc_in : 12'd0;
         s1_syn   <= in_valid ? calc_syn(hc_in) : 4'd0;
      end
   end

   logic [11:0] fix_mask;
   logic        corr_next;
   logic        uncorr_next;
   logic [7:0]  data_next;
   logic [3:0]  syn_next;

   // Syndromes 1..12 name the faulty bit position directly (position k = bit k-1).
   always_comb begin
      fix_mask    = '0;
      corr_next   = 1'b0;
      uncorr_next = 1'b0;
      data_next   = '0;
      syn_next    = '0;
      if (s1_valid) begin
         syn_next = s1_syn;
         if (s1_syn != 4'd0 && s1_syn <= 4'd12) begin
            fix_mask  = 12'(1) << (s1_syn - 4'd1);
            corr_next = 1'b1;
         end else if (s1_syn >= 4'd13) begin
            uncorr_next = 1'b1;
         end
         data_next = extract(s1_code ^ fix_mask);
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         out_valid    <= 1'b0;
         data_out     <= '0;
         err_corr     <= 1'b0;
         err_uncorr   <= 1'b0;
         syndrome_out <= '0;
      end else begin
         out_valid    <= s1_valid;
         data_out     <= data_next;
         err_corr     <= corr_next;
         err_uncorr   <= uncorr_next;
         syndrome_out <= syn_next;
      end
   end

   // Clear wins over a coincident increment; counts stick at all-ones.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else begin
         if (corr_next && corr_cnt != CNT_MAX)
            corr_cnt <= corr_cnt + 1'b1;
         if (uncorr_next && uncorr_cnt != CNT_MAX)
            uncorr_cnt <= uncorr_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hamming_decoder : scoreboard bench for hamming_decoder (CNT_W=16 and 2)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_hamming_decoder;

   typedef struct packed {
      logic [7:0] data;
      logic       corr;
      logic       uncorr;
      logic [3:0] syn;
   } exp_t;

   logic        clk = 1'b0;
   logic        arstn;
   logic        in_valid;
   logic [11:0] hc_in;
   logic        cnt_clr;

   logic        out_valid;
   logic [7:0]  data_out;
   logic        err_corr;
   logic        err_uncorr;
   logic [3:0]  syndrome_out;
   logic [15:0] corr_cnt;
   logic [15:0] uncorr_cnt;

   logic        out_valid_s;
   logic [7:0]  data_out_s;
   logic        err_corr_s;
   logic        err_uncorr_s;
   logic [3:0]  syndrome_out_s;
   logic [1:0]  corr_cnt_s;
   logic [1:0]  uncorr_cnt_s;

   exp_t        q[$];
   int          checks   = 0;
   int          failures = 0;
   int unsigned exp_corr0   = 0;
   int unsigned exp_uncorr0 = 0;
   int unsigned exp_corr1   = 0;
   int unsigned exp_uncorr1 = 0;

   always #5 clk = ~clk;

   hamming_decoder #(.CNT_W(16)) dut (
      .clk(clk), .arstn(arstn), .in_valid(in_valid), .hc_in(hc_in),
      .cnt_clr(cnt_clr), .out_valid(out_valid), .data_out(data_out),
      .err_corr(err_corr), .err_uncorr(err_uncorr),
      .syndrome_out(syndrome_out), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   hamming_decoder #(.CNT_W(2)) dut_small (
      .clk(clk), .arstn(arstn), .in_valid(in_valid), .hc_in(hc_in),
      .cnt_clr(cnt_clr), .out_valid(out_valid_s), .data_out(data_out_s),
      .err_corr(err_corr_s), .err_uncorr(err_uncorr_s),
      .syndrome_out(syndrome_out_s), .corr_cnt(corr_cnt_s),
      .uncorr_cnt(uncorr_cnt_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per delivered word; idle cycles must be all-zero.
   always @(negedge clk) begin
      if (arstn === 1'b1) begin
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_word", {20'd0, data_out, syndrome_out}, 32'd0);
               if (data_out == 8'd0 && syndrome_out == 4'd0)
                  chk("unexpected_word_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("word", {18'd0, data_out, err_corr, err_uncorr, syndrome_out},
                   {18'd0, e});
            end
         end else begin
            chk("idle_zero", {18'd0, data_out, err_corr, err_uncorr, syndrome_out}, 32'd0);
         end
      end
   end

   task automatic send(input logic [11:0] code, input logic [7:0] data,
                       input logic corr, input logic uncorr, input logic [3:0] syn);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      hc_in    = code;
      q.push_back('{data: data, corr: corr, uncorr: uncorr, syn: syn});
      if (corr) begin
         exp_corr0++;
         if (exp_corr1 < 3) exp_corr1++;
      end
      if (uncorr) begin
         exp_uncorr0++;
         if (exp_uncorr1 < 3) exp_uncorr1++;
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      hc_in    = 12'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_corr16"},  {16'd0, corr_cnt},     exp_corr0);
      chk({tag, "_uncorr16"}, {16'd0, uncorr_cnt},  exp_uncorr0);
      chk({tag, "_corr2"},   {30'd0, corr_cnt_s},   exp_corr1);
      chk({tag, "_uncorr2"}, {30'd0, uncorr_cnt_s}, exp_uncorr1);
   endtask

   initial begin
      arstn    = 1'b0;
      in_valid = 1'b0;
      hc_in    = 12'd0;
      cnt_clr  = 1'b0;
      #1;
      chk("reset_outputs", {18'd0, out_valid, data_out, err_corr, err_uncorr, syndrome_out}, 32'd0);
      chk_counts("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      arstn = 1'b1;

      // Isolated words: clean, data-bit error, parity-bit error, uncorrectable.
      send(12'hA27, 8'hA5, 1'b0, 1'b0, 4'd0);  idle(3);
      send(12'hA07, 8'hA5, 1'b1, 1'b0, 4'd6);  idle(3);
      send(12'hA26, 8'hA5, 1'b1, 1'b0, 4'd1);  idle(3);
      send(12'h226, 8'h25, 1'b0, 1'b1, 4'd13); idle(3);
      chk_counts("single");

      // Back-to-back stream then idle.
      send(12'hA27, 8'hA5, 1'b0, 1'b0, 4'd0);
      send(12'hA07, 8'hA5, 1'b1, 1'b0, 4'd6);
      send(12'hA26, 8'hA5, 1'b1, 1'b0, 4'd1);
      send(12'h226, 8'h25, 1'b0, 1'b1, 4'd13);
      idle(3);
      chk_counts("stream");

      // More patterns: other data bytes and single errors at several positions.
      send(12'h000, 8'h00, 1'b0, 1'b0, 4'd0);
      send(12'hF77, 8'hFF, 1'b0, 1'b0, 4'd0);
      send(12'hA25, 8'hA5, 1'b1, 1'b0, 4'd2);
      send(12'hA2F, 8'hA5, 1'b1, 1'b0, 4'd4);
      send(12'hB27, 8'hA5, 1'b1, 1'b0, 4'd9);
      send(12'hE27, 8'hA5, 1'b1, 1'b0, 4'd11);
      idle(3);
      chk_counts("saturate");

      // Clear coincident with an error output: the increment is dropped.
      send(12'hA07, 8'hA5, 1'b1, 1'b0, 4'd6);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      hc_in    = 12'd0;
      cnt_clr  = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr     = 1'b0;
      exp_corr0   = 0;
      exp_uncorr0 = 0;
      exp_corr1   = 0;
      exp_uncorr1 = 0;
      chk_counts("clear");
      idle(2);
      chk_counts("after_clear");

      // Asynchronous reset mid-stream discards in-flight words.
      send(12'hA07, 8'hA5, 1'b1, 1'b0, 4'd6);
      send(12'h226, 8'h25, 1'b0, 1'b1, 4'd13);
      @(posedge clk);
      #2;
      arstn    = 1'b0;
      in_valid = 1'b0;
      hc_in    = 12'd0;
      #1;
      chk("midreset_outputs", {18'd0, out_valid, data_out, err_corr, err_uncorr, syndrome_out}, 32'd0);
      q.delete();
      exp_corr0   = 0;
      exp_uncorr0 = 0;
      exp_corr1   = 0;
      exp_uncorr1 = 0;
      chk_counts("midreset");
      @(negedge clk);
      arstn = 1'b1;
      idle(4);
      send(12'hF77, 8'hFF, 1'b0, 1'b0, 4'd0);
      send(12'hA26, 8'hA5, 1'b1, 1'b0, 4'd1);
      idle(3);
      chk_counts("post_reset");

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      chk("drain", q.size(), 32'd0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
